// File: rtl/prisoner_box_core_pkg.sv
// prisoner_pkg: shared command encoding and default widths for the sealed-box core
package prisoner_pkg;
  localparam int DATA_W = 8;
  localparam int KEY_W = 32;
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    STORE = 3'b001,
    OPEN  = 3'b010,
    SEAL  = 3'b100
  } cmd_e;
endpackage

// File: rtl/prisoner_box_core_if.sv
// prisoner_box_if: command/data bus between the puzzle controller and one box
interface prisoner_box_if
  import prisoner_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int KW = KEY_W
);
  logic [2:0]    state_reg;
  logic [DW-1:0] input_data;
  logic [KW-1:0] guard_key;
  logic [DW-1:0] output_data;
  modport master (output state_reg, input_data, guard_key, input output_data);
  modport slave  (input state_reg, input_data, guard_key, output output_data);
endinterface

// File: rtl/prisoner_box_core_key_cmp.sv
// key_cmp: purely combinational full-width key equality
module key_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);
  assign eq = a == b;
endmodule

// File: rtl/prisoner_box_core.sv
// prisoner_box_core: one sealed storage byte released only to a matching key, with lockout
module prisoner_box_core
  import prisoner_pkg::*;
#(
  parameter int MAX_TRIES = 3
) (
  input logic          clk,
  input logic          rst_n,
  prisoner_box_if.slave bus
);
  localparam logic [3:0] MAX = 4'(MAX_TRIES);
  logic [DATA_W-1:0] content;
  logic [KEY_W-1:0]  key;
  logic              full, sealed, locked_out, key_ok;
  logic [3:0]        fail_cnt, fail_nxt;
  logic              is_store, is_seal, is_open, do_store, do_seal, good_open, bad_key;
  key_cmp #(.W(KEY_W)) u_cmp (.a(bus.guard_key), .b(key), .eq(key_ok));
  always_comb begin
    is_store  = bus.state_reg == STORE;
    is_seal   = bus.state_reg == SEAL;
    is_open   = bus.state_reg == OPEN;
    do_store  = is_store && !sealed && !locked_out;
    do_seal   = is_seal && full && !locked_out;
    good_open = is_open && full && !locked_out && key_ok;
    bad_key   = is_open && full && !key_ok;
    fail_nxt  = fail_cnt >= MAX ? MAX : fail_cnt + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      content         <= '0;
      key             <= '0;
      full            <= 1'b0;
      sealed          <= 1'b0;
      locked_out      <= 1'b0;
      fail_cnt        <= '0;
      bus.output_data <= '0;
    end else begin
      if (do_store) begin
        content  <= bus.input_data;
        key      <= bus.guard_key;
        full     <= 1'b1;
        fail_cnt <= '0;
      end
      if (do_seal) sealed <= 1'b1;
      if (is_open) bus.output_data <= good_open ? content : '0;
      if (good_open) begin
        sealed   <= 1'b0;
        fail_cnt <= '0;
      end
      // lockout latches on the attempt that brings the counter to the limit
      if (bad_key) begin
        fail_cnt <= fail_nxt;
        if (fail_nxt == MAX) locked_out <= 1'b1;
      end
    end
endmodule

// File: tb/tb_prisoner_box_core.sv
// tb_prisoner_box_core: directed vectors with hand-computed expectations
module tb_prisoner_box_core;
  import prisoner_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  prisoner_box_if bus ();
  prisoner_box_core #(.MAX_TRIES(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cmd(input logic [2:0] c, input logic [7:0] d, input logic [31:0] k);
    bus.state_reg  = c;
    bus.input_data = d;
    bus.guard_key  = k;
    @(posedge clk);
    #1;
    bus.state_reg = IDLE;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.state_reg  = IDLE;
    bus.input_data = '0;
    bus.guard_key  = '0;
    #3;
    check("reset_out", 32'(bus.output_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_lock", 32'(dut.locked_out), 32'h0);
    cmd(STORE, 8'hAB, 32'hDEADBEEF);
    check("rt_store", 32'(bus.output_data), 32'h0);
    cmd(SEAL, 8'h00, 32'h0);
    check("rt_seal", 32'(bus.output_data), 32'h0);
    check("rt_sealed", 32'(dut.sealed), 32'h1);
    cmd(OPEN, 8'h00, 32'hDEADBEEF);
    check("rt_open", 32'(bus.output_data), 32'hAB);
    check("rt_unsealed", 32'(dut.sealed), 32'h0);
    cmd(STORE, 8'hFE, 32'hDEADBEEF);
    check("ow_store_hold", 32'(bus.output_data), 32'hAB);
    cmd(OPEN, 8'h00, 32'hDEADBEEF);
    check("ow_open", 32'(bus.output_data), 32'hFE);
    cmd(SEAL, 8'h00, 32'h0);
    check("ow_seal_hold", 32'(bus.output_data), 32'hFE);
    do_reset();
    cmd(STORE, 8'h11, 32'hCAFEF00D);
    cmd(SEAL, 8'h00, 32'h0);
    cmd(STORE, 8'h22, 32'hCAFEF00D);
    cmd(OPEN, 8'h00, 32'hCAFEF00D);
    check("sealed_protect", 32'(bus.output_data), 32'h11);
    cmd(STORE, 8'h5A, 32'h12345678);
    for (int i = 1; i <= 3; i++) begin
      cmd(OPEN, 8'h00, 32'h0);
      check("bad_open_out", 32'(bus.output_data), 32'h0);
      check("bad_open_cnt", 32'(dut.fail_cnt), 32'(i));
    end
    check("locked", 32'(dut.locked_out), 32'h1);
    cmd(OPEN, 8'h00, 32'h12345678);
    check("locked_good_key", 32'(bus.output_data), 32'h0);
    cmd(OPEN, 8'h00, 32'h0);
    check("fail_saturate", 32'(dut.fail_cnt), 32'h3);
    cmd(STORE, 8'h77, 32'h12345678);
    check("locked_store_ign", 32'(dut.content), 32'h5A);
    do_reset();
    check("lock_cleared", 32'(dut.locked_out), 32'h0);
    cmd(OPEN, 8'h00, 32'h12345678);
    check("empty_open_out", 32'(bus.output_data), 32'h0);
    check("empty_open_cnt", 32'(dut.fail_cnt), 32'h0);
    cmd(3'b111, 8'h99, 32'h12345678);
    check("illegal_out", 32'(bus.output_data), 32'h0);
    check("illegal_full", 32'(dut.full), 32'h0);
    cmd(STORE, 8'h5A, 32'h12345678);
    cmd(OPEN, 8'h00, 32'h12345678);
    check("post_reset_open", 32'(bus.output_data), 32'h5A);
    cmd(STORE, 8'hAB, 32'hDEADBEEF);
    cmd(OPEN, 8'h00, 32'hDEADBEEF);
    check("pre_async", 32'(bus.output_data), 32'hAB);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(bus.output_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd(OPEN, 8'h00, 32'hDEADBEEF);
    check("reset_discard", 32'(bus.output_data), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
